// File: rtl/csync_decoder.sv
`timescale 1ns/1ps
// Composite-sync separator: regenerated h_sync with flywheel, v_sync, field parity, line count, lock.
// h_sync rises SYNC_STAGES+GLITCH_MIN+1 cycles after the sync leading edge; v_sync one cycle after pw hits BROAD_MIN.
module csync_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CNT_W           = 14,
  parameter int GLITCH_MIN      = 50,
  parameter int LINE_MIN        = 4800,
  parameter int LINE_MAX        = 8000,
  parameter int HALF_LO         = 1600,
  parameter int HALF_HI         = 4800,
  parameter int BROAD_MIN       = 1500,
  parameter int HS_OUT_W        = 470,
  parameter int LOCK_LINES      = 8,
  parameter int MISS_MAX        = 4
) (
  input  logic       sysClock,
  input  logic       nReset,
  input  logic       csync_in,
  output logic       h_sync,
  output logic       v_sync,
  output logic       field,
  output logic [9:0] line_count,
  output logic       locked
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int GOOD_W = $clog2(LOCK_LINES + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       pw, timer, phase, hs_cnt;
  logic                   armed;
  logic [GOOD_W-1:0]      good, good_next;
  logic [MISS_W-1:0]      miss;
  logic                   qual, real_edge, synth_edge, any_edge, in_range, broad_hit, short_trail;

  // Assert asynchronously, release two clocks later so every state flop leaves reset together.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{IDLE}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], csync_in};
  end
  assign s = sync_q[SYNC_STAGES-1] ^ IDLE;

  always_comb begin
    qual        = (pw == CNT_W'(GLITCH_MIN));
    real_edge   = qual && (armed || (timer >= CNT_W'(LINE_MIN)));
    synth_edge  = locked && (timer == CNT_W'(LINE_MAX)) && !real_edge;
    any_edge    = real_edge || synth_edge;
    in_range    = (timer >= CNT_W'(LINE_MIN)) && (timer <= CNT_W'(LINE_MAX));
    good_next   = in_range ? ((good == GOOD_W'(LOCK_LINES)) ? good : good + 1'b1) : GOOD_W'(1);
    broad_hit   = (pw == CNT_W'(BROAD_MIN)) && !v_sync;
    // pw still holds the finished pulse width for the single cycle after s falls.
    short_trail = !s && (pw >= CNT_W'(GLITCH_MIN)) && (pw < CNT_W'(BROAD_MIN));
  end

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      pw         <= '0;
      timer      <= '0;
      phase      <= '0;
      hs_cnt     <= '0;
      armed      <= 1'b1;
      good       <= '0;
      miss       <= '0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      field      <= 1'b0;
      line_count <= '0;
      locked     <= 1'b0;
    end else begin
      if (!s)                 pw <= '0;
      else if (pw != CNT_MAX) pw <= pw + 1'b1;

      if (any_edge)              timer <= '0;
      else if (timer != CNT_MAX) timer <= timer + 1'b1;

      if (qual) phase <= timer;

      if (real_edge) begin
        armed <= 1'b0;
        miss  <= '0;
        good  <= good_next;
        if (good_next == GOOD_W'(LOCK_LINES)) locked <= 1'b1;
      end else if (synth_edge) begin
        miss <= miss + 1'b1;
        if (miss == MISS_W'(MISS_MAX - 1)) begin
          locked <= 1'b0;
          armed  <= 1'b1;
          good   <= '0;
        end
      end

      if (any_edge) begin
        h_sync <= 1'b1;
        hs_cnt <= CNT_W'(HS_OUT_W - 1);
      end else if (h_sync) begin
        if (hs_cnt == '0) h_sync <= 1'b0;
        else              hs_cnt <= hs_cnt - 1'b1;
      end

      if (broad_hit) begin
        v_sync     <= 1'b1;
        line_count <= 10'd1;
        field      <= (phase >= CNT_W'(HALF_LO)) && (phase < CNT_W'(HALF_HI));
      end else begin
        if (any_edge && (line_count != 10'h3ff)) line_count <= line_count + 1'b1;
        if (short_trail && v_sync)               v_sync <= 1'b0;
      end
    end
  end
endmodule
